// File: rtl/i8008_state_seq.sv
// i8008_state_seq: machine-state sequencer for the i8008 core.
// Produces the per-clock T-state code and tracks the machine-cycle index,
// the cycle type, READY wait states, HLT stop and interrupt acknowledge.
//
// Ports:
//   clk        core clock; all state changes on the rising edge
//   rst_n      asynchronous active-low reset
//   ready      memory/IO ready, sampled in T2 and WAIT
//   intr       level interrupt request, latched into a pending flag
//   cyc_len    machine-cycle length, sampled in T3 (01:T3, 10:T4, else T5)
//   cyc_last   current cycle is the instruction's last, sampled at cycle end
//   halt       decoded HLT, honoured only in T3 of cycle 0
//   next_type  cycle type for the next non-first cycle, sampled with cyc_last
//   state      current T-state code
//   cyc_idx    machine-cycle index within the instruction
//   cyc_type   current cycle type (PCI/PCR/PCC/PCW)
//   int_ack    high through a cycle that was started by T1I
//   sync       toggles every clock
module i8008_state_seq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ready,
  input  logic       intr,
  input  logic [1:0] cyc_len,
  input  logic       cyc_last,
  input  logic       halt,
  input  logic [1:0] next_type,
  output logic [2:0] state,
  output logic [1:0] cyc_idx,
  output logic [1:0] cyc_type,
  output logic       int_ack,
  output logic       sync
);

  localparam int unsigned STATE_W = 3;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned TYPE_W  = 2;
  localparam int unsigned LEN_W   = 2;

  localparam logic [STATE_W-1:0] T1      = 3'b010;
  localparam logic [STATE_W-1:0] T1I     = 3'b011;
  localparam logic [STATE_W-1:0] T2      = 3'b001;
  localparam logic [STATE_W-1:0] WAIT    = 3'b000;
  localparam logic [STATE_W-1:0] T3      = 3'b100;
  localparam logic [STATE_W-1:0] STOPPED = 3'b110;
  localparam logic [STATE_W-1:0] T4      = 3'b111;
  localparam logic [STATE_W-1:0] T5      = 3'b101;

  localparam logic [TYPE_W-1:0] PCI     = 2'b00;
  localparam logic [LEN_W-1:0]  LEN_T3  = 2'b01;
  localparam logic [LEN_W-1:0]  LEN_T4  = 2'b10;
  localparam logic [IDX_W-1:0]  IDX_MAX = 2'd2;

  logic [STATE_W-1:0] state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TYPE_W-1:0]  type_q, type_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ack_q, ack_d;
  logic               pend_q, pend_d;
  logic               sync_q;

  // Interrupt counts as pending if latched earlier or asserted on this edge.
  logic pend_now;
  logic end_of_cycle;

  assign pend_now = pend_q | intr;

  // State and bookkeeping registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= T1;
      idx_q   <= '0;
      type_q  <= PCI;
      len_q   <= '0;
      ack_q   <= 1'b0;
      pend_q  <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      type_q  <= type_d;
      len_q   <= len_d;
      ack_q   <= ack_d;
      pend_q  <= pend_d;
      sync_q  <= ~sync_q;
    end
  end

  // Next T-state; flags the last T-state of a machine cycle.
  always_comb begin
    state_d      = state_q;
    end_of_cycle = 1'b0;
    case (state_q)
      T1, T1I:  state_d = T2;
      T2, WAIT: state_d = ready ? T3 : WAIT;
      T3: begin
        // Halt takes priority over cycle length and last-cycle decode.
        if (halt && (idx_q == '0)) begin
          state_d = STOPPED;
        end else if (cyc_len == LEN_T3) begin
          end_of_cycle = 1'b1;
        end else begin
          state_d = T4;
        end
      end
      T4: begin
        if (len_q == LEN_T4) begin
          end_of_cycle = 1'b1;
        end else begin
          state_d = T5;
        end
      end
      T5:      end_of_cycle = 1'b1;
      STOPPED: if (pend_now) state_d = T1I;
      default: state_d = T1;
    endcase
    // Interrupts are only taken between instructions.
    if (end_of_cycle) begin
      state_d = (cyc_last && pend_now) ? T1I : T1;
    end
  end

  // Next values for cycle index, type, ack, pending flag and latched length.
  always_comb begin
    idx_d  = idx_q;
    type_d = type_q;
    ack_d  = ack_q;
    len_d  = len_q;
    pend_d = pend_now;
    if (state_q == T3) begin
      len_d = cyc_len;
    end
    if (state_d == T1I) begin
      idx_d  = '0;
      type_d = PCI;
      ack_d  = 1'b1;
      pend_d = 1'b0;
    end else if (end_of_cycle) begin
      ack_d = 1'b0;
      // A non-last cycle at the maximum index wraps to a fresh PCI cycle.
      if (cyc_last || (idx_q == IDX_MAX)) begin
        idx_d  = '0;
        type_d = PCI;
      end else begin
        idx_d  = idx_q + IDX_W'(1);
        type_d = next_type;
      end
    end
  end

  assign state    = state_q;
  assign cyc_idx  = idx_q;
  assign cyc_type = type_q;
  assign int_ack  = ack_q;
  assign sync     = sync_q;

endmodule

// File: tb/tb_i8008_state_seq.sv
// tb_i8008_state_seq: testbench for i8008_state_seq. Directed vector table,
// hand-written asynchronous reset sequence, then randomized machine cycles
// checked against a cycle-level reference model.
module tb_i8008_state_seq;

  localparam logic [2:0] T1      = 3'b010;
  localparam logic [2:0] T1I     = 3'b011;
  localparam logic [2:0] T2      = 3'b001;
  localparam logic [2:0] WAIT    = 3'b000;
  localparam logic [2:0] T3      = 3'b100;
  localparam logic [2:0] STOPPED = 3'b110;
  localparam logic [2:0] T4      = 3'b111;
  localparam logic [2:0] T5      = 3'b101;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ready = 1'b1;
  logic       intr = 1'b0;
  logic [1:0] cyc_len = 2'b01;
  logic       cyc_last = 1'b1;
  logic       halt = 1'b0;
  logic [1:0] next_type = 2'b00;
  logic [2:0] state;
  logic [1:0] cyc_idx;
  logic [1:0] cyc_type;
  logic       int_ack;
  logic       sync;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model of the observable sequencer state.
  logic       m_sync = 1'b0;
  logic [2:0] m_state;
  logic [1:0] m_idx;
  logic [1:0] m_type;
  logic       m_ack;
  logic       m_pend;

  typedef struct {
    logic       rdy;
    logic [1:0] len;
    logic       last;
    logic [1:0] nt;
    logic       hlt;
    logic       irq;
    logic [2:0] st;
    logic [1:0] idx;
    logic [1:0] typ;
    logic       ack;
  } vec_t;

  vec_t tab[$];

  i8008_state_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ready     (ready),
    .intr      (intr),
    .cyc_len   (cyc_len),
    .cyc_last  (cyc_last),
    .halt      (halt),
    .next_type (next_type),
    .state     (state),
    .cyc_idx   (cyc_idx),
    .cyc_type  (cyc_type),
    .int_ack   (int_ack),
    .sync      (sync)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic rdy, input logic [1:0] len, input logic last,
                              input logic [1:0] nt, input logic hlt, input logic irq,
                              input logic [2:0] st, input logic [1:0] idx,
                              input logic [1:0] typ, input logic ack);
    vec_t v;
    v.rdy = rdy; v.len = len; v.last = last; v.nt = nt; v.hlt = hlt; v.irq = irq;
    v.st = st; v.idx = idx; v.typ = typ; v.ack = ack;
    return v;
  endfunction

  task automatic check(input string name, input logic [2:0] st, input logic [1:0] idx,
                       input logic [1:0] typ, input logic ack, input logic sy);
    tests_run++;
    if ({state, cyc_idx, cyc_type, int_ack, sync} !== {st, idx, typ, ack, sy}) begin
      tests_failed++;
      $display("FAIL %s: got state=%b idx=%0d type=%b ack=%b sync=%b, want state=%b idx=%0d type=%b ack=%b sync=%b",
               name, state, cyc_idx, cyc_type, int_ack, sync, st, idx, typ, ack, sy);
    end
  endtask

  task automatic drive(input logic rdy, input logic [1:0] len, input logic last,
                       input logic [1:0] nt, input logic hlt, input logic irq);
    ready = rdy; cyc_len = len; cyc_last = last; next_type = nt; halt = hlt; intr = irq;
  endtask

  // Advance one clock and sample just after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    m_sync = ~m_sync;
  endtask

  // One randomized machine cycle starting in T1 or T1I; the expected state
  // sequence is laid out up front from the cycle length and wait count.
  task automatic run_mcycle();
    logic [2:0] seq[$];
    logic [1:0] len, nt;
    logic       last, hlt_here, pend;
    logic       r_rdy, r_last, r_hlt, irq;
    logic [1:0] r_len, r_nt;
    int         tlen, nw, n;
    len      = 2'($urandom_range(0, 3));
    tlen     = (len == 2'b01) ? 3 : ((len == 2'b10) ? 4 : 5);
    nw       = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
    last     = ($urandom_range(0, 2) != 0);
    nt       = 2'($urandom_range(0, 3));
    hlt_here = (m_idx == 2'd0) && ($urandom_range(0, 7) == 0);
    seq.delete();
    seq.push_back(m_state);
    seq.push_back(T2);
    for (int w = 0; w < nw; w++) seq.push_back(WAIT);
    seq.push_back(T3);
    if (tlen >= 4) seq.push_back(T4);
    if (tlen == 5) seq.push_back(T5);
    n = hlt_here ? (3 + nw) : seq.size();
    for (int k = 0; k < n; k++) begin
      r_rdy  = 1'($urandom_range(0, 1));
      r_len  = 2'($urandom_range(0, 3));
      r_last = 1'($urandom_range(0, 1));
      r_nt   = 2'($urandom_range(0, 3));
      r_hlt  = 1'($urandom_range(0, 1));
      irq    = ($urandom_range(0, 9) == 0);
      if (seq[k] == T2 || seq[k] == WAIT) r_rdy = (k <= nw) ? 1'b0 : 1'b1;
      if (seq[k] == T3) begin
        r_len = len;
        if (m_idx == 2'd0) r_hlt = hlt_here;
      end
      if (k == n - 1 && !hlt_here) begin
        r_last = last;
        r_nt   = nt;
      end
      drive(r_rdy, r_len, r_last, r_nt, r_hlt, irq);
      pend   = m_pend | irq;
      m_pend = pend;
      step();
      if (k < n - 1) begin
        m_state = seq[k+1];
      end else if (hlt_here) begin
        m_state = STOPPED;
      end else if (last) begin
        m_idx  = 2'd0;
        m_type = 2'b00;
        if (pend) begin
          m_state = T1I; m_ack = 1'b1; m_pend = 1'b0;
        end else begin
          m_state = T1; m_ack = 1'b0;
        end
      end else begin
        m_state = T1;
        m_ack   = 1'b0;
        if (m_idx == 2'd2) begin
          m_idx = 2'd0; m_type = 2'b00;
        end else begin
          m_idx = m_idx + 2'd1; m_type = nt;
        end
      end
      check("rnd_cycle", m_state, m_idx, m_type, m_ack, m_sync);
    end
    if (hlt_here) begin
      int waitc, c;
      waitc = int'($urandom_range(0, 6));
      c = 0;
      while (m_state == STOPPED) begin
        irq = (c >= waitc) ? 1'b1 : ($urandom_range(0, 15) == 0);
        drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), irq);
        pend = m_pend | irq;
        step();
        if (pend) begin
          m_state = T1I; m_idx = 2'd0; m_type = 2'b00; m_ack = 1'b1; m_pend = 1'b0;
        end
        check("rnd_stop", m_state, m_idx, m_type, m_ack, m_sync);
        c++;
      end
    end
  endtask

  initial begin
    // Minimal 3-clock cycles.
    for (int i = 0; i < 2; i++) begin
      tab.push_back(mk(1, 2'b01, 1, 2'b00, 0, 0, T2, 0, 2'b00, 0));
      tab.push_back(mk(1, 2'b01, 1, 2'b00, 0, 0, T3, 0, 2'b00, 0));
      tab.push_back(mk(1, 2'b01, 1, 2'b00, 0, 0, T1, 0, 2'b00, 0));
    end
    // Three-cycle instruction: 5, 4 then 3 T-states; cyc_len change in T4 ignored.
    tab.push_back(mk(1, 2'b11, 0, 2'b10, 0, 0, T2, 0, 2'b00, 0));
    tab.push_back(mk(1, 2'b11, 0, 2'b10, 0, 0, T3, 0, 2'b00, 0));
    tab.push_back(mk(1, 2'b11, 0, 2'b10, 0, 0, T4, 0, 2'b00, 0));
    tab.push_back(mk(1, 2'b11, 0, 2'b10, 0, 0, T5, 0, 2'b00, 0));
    tab.push_back(mk(1, 2'b11, 0, 2'b10, 0, 0, T1, 1, 2'b10, 0));
    tab.push_back(mk(1, 2'b10, 0, 2'b11, 0, 0, T2, 1, 2'b10, 0));
    tab.push_back(mk(1, 2'b10, 0, 2'b11, 0, 0, T3, 1, 2'b10, 0));
    tab.push_back(mk(1, 2'b10, 0, 2'b11, 0, 0, T4, 1, 2'b10, 0));
    tab.push_back(mk(1, 2'b01, 0, 2'b11, 0, 0, T1, 2, 2'b11, 0));
    tab.push_back(mk(1, 2'b01, 1, 2'b00, 0, 0, T2, 2, 2'b11, 0));
    tab.push_back(mk(1, 2'b01, 1, 2'b00, 0, 0, T3, 2, 2'b11, 0));
    tab.push_back(mk(1, 2'b01, 1, 2'b00, 0, 0, T1, 0, 2'b00, 0));
    // Three WAIT states.
    tab.push_back(mk(1, 2'b01, 1, 2'b00, 0, 0, T2,   0, 2'b00, 0));
    tab.push_back(mk(0, 2'b01, 1, 2'b00, 0, 0, WAIT, 0, 2'b00, 0));
    tab.push_back(mk(0, 2'b01, 1, 2'b00, 0, 0, WAIT, 0, 2'b00, 0));
    tab.push_back(mk(0, 2'b01, 1, 2'b00, 0, 0, WAIT, 0, 2'b00, 0));
    tab.push_back(mk(1, 2'b01, 1, 2'b00, 0, 0, T3,   0, 2'b00, 0));
    tab.push_back(mk(1, 2'b01, 1, 2'b00, 0, 0, T1,   0, 2'b00, 0));
    // HLT, ten stopped clocks, then a one-clock interrupt pulse.
    tab.push_back(mk(1, 2'b01, 1, 2'b00, 0, 0, T2,      0, 2'b00, 0));
    tab.push_back(mk(1, 2'b01, 1, 2'b00, 0, 0, T3,      0, 2'b00, 0));
    tab.push_back(mk(1, 2'b01, 1, 2'b00, 1, 0, STOPPED, 0, 2'b00, 0));
    for (int i = 0; i < 10; i++)
      tab.push_back(mk(1, 2'b01, 1, 2'b00, 0, 0, STOPPED, 0, 2'b00, 0));
    tab.push_back(mk(1, 2'b01, 1, 2'b00, 0, 1, T1I, 0, 2'b00, 1));
    tab.push_back(mk(1, 2'b01, 1, 2'b00, 0, 0, T2,  0, 2'b00, 1));
    tab.push_back(mk(1, 2'b01, 1, 2'b00, 0, 0, T3,  0, 2'b00, 1));
    tab.push_back(mk(1, 2'b01, 1, 2'b00, 0, 0, T1,  0, 2'b00, 0));
    // Interrupt during cycle 1 of a two-cycle instruction.
    tab.push_back(mk(1, 2'b01, 0, 2'b10, 0, 0, T2,  0, 2'b00, 0));
    tab.push_back(mk(1, 2'b01, 0, 2'b10, 0, 0, T3,  0, 2'b00, 0));
    tab.push_back(mk(1, 2'b01, 0, 2'b10, 0, 0, T1,  1, 2'b10, 0));
    tab.push_back(mk(1, 2'b01, 1, 2'b00, 0, 1, T2,  1, 2'b10, 0));
    tab.push_back(mk(1, 2'b01, 1, 2'b00, 0, 0, T3,  1, 2'b10, 0));
    tab.push_back(mk(1, 2'b01, 1, 2'b00, 0, 0, T1I, 0, 2'b00, 1));
    tab.push_back(mk(1, 2'b01, 1, 2'b00, 0, 0, T2,  0, 2'b00, 1));
    tab.push_back(mk(1, 2'b01, 1, 2'b00, 0, 0, T3,  0, 2'b00, 1));
    tab.push_back(mk(1, 2'b01, 1, 2'b00, 0, 0, T1,  0, 2'b00, 0));
    tab.push_back(mk(1, 2'b01, 1, 2'b00, 0, 0, T2,  0, 2'b00, 0));

    // Reset state, then release away from the clock edge.
    #12;
    check("reset", T1, 2'd0, 2'b00, 1'b0, 1'b0);
    rst_n  = 1'b1;
    m_sync = 1'b0;

    for (int i = 0; i < tab.size(); i++) begin
      drive(tab[i].rdy, tab[i].len, tab[i].last, tab[i].nt, tab[i].hlt, tab[i].irq);
      step();
      check($sformatf("tab%0d", i), tab[i].st, tab[i].idx, tab[i].typ, tab[i].ack, m_sync);
    end

    // Asynchronous reset in WAIT with cyc_idx=1 and an interrupt pending.
    drive(1, 2'b01, 0, 2'b10, 0, 0);
    step();
    step();
    check("pre_rst_t1", T1, 2'd1, 2'b10, 1'b0, m_sync);
    drive(1, 2'b01, 0, 2'b10, 0, 1);
    step();
    drive(0, 2'b01, 0, 2'b10, 0, 0);
    step();
    check("pre_rst_wait", WAIT, 2'd1, 2'b10, 1'b0, m_sync);
    #2;
    rst_n = 1'b0;
    #1;
    m_sync = 1'b0;
    check("async_rst", T1, 2'd0, 2'b00, 1'b0, m_sync);
    #2;
    rst_n = 1'b1;
    drive(1, 2'b01, 1, 2'b00, 0, 0);
    step();
    check("post_rst_t2", T2, 2'd0, 2'b00, 1'b0, m_sync);
    step();
    check("post_rst_t3", T3, 2'd0, 2'b00, 1'b0, m_sync);
    step();
    check("post_rst_no_t1i", T1, 2'd0, 2'b00, 1'b0, m_sync);

    // Randomized machine cycles against the model.
    m_state = T1; m_idx = 2'd0; m_type = 2'b00; m_ack = 1'b0; m_pend = 1'b0;
    for (int i = 0; i < 400; i++) run_mcycle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, got running want finished");
    $fatal(1);
  end

endmodule

// File: doc/i8008_state_seq.md
# i8008_state_seq

Machine-state sequencer for the i8008 core. It generates the per-clock T-state code (T1, T1I, T2, WAIT, T3, T4, T5, STOPPED) on the shared `state` bus. That bus drives the scratchpad address selector, the bus interface and the decode logic. The sequencer also tracks the machine-cycle index within an instruction, the cycle type (PCI/PCR/PCC/PCW), READY wait insertion, HLT stop, and interrupt acknowledge.

## Interface
Parameters: none. State codes come from `common.svh` and are fixed: T1=010, T1I=011, T2=001, WAIT=000, T3=100, STOPPED=110, T4=111, T5=101.
- clk  in  1  single core clock; all state changes on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- ready  in  1  memory/IO ready; sampled in T2 and WAIT
- intr  in  1  interrupt request, level; latched into a pending flag
- cyc_len  in  2  length of the current machine cycle, sampled in T3: 01=ends after T3, 10=ends after T4, 11/00=ends after T5
- cyc_last  in  1  current machine cycle is the last of the instruction; sampled in the last T-state of the cycle
- halt  in  1  decoded HLT; honoured only in T3 of cycle index 0
- next_type  in  2  cycle type for the next non-first cycle; sampled with cyc_last
- state  out  3  current T-state code
- cyc_idx  out  2  machine-cycle index within the instruction (0..2)
- cyc_type  out  2  current cycle type: PCI=00, PCR=10, PCC=01, PCW=11
- int_ack  out  1  high while the current cycle was started by T1I; held through that cycle
- sync  out  1  toggles every clk; 0 in the first half of each T-state pair

## Operation
- Reset (rst_n low, any time, including mid-cycle) forces: state=T1, cyc_idx=0, cyc_type=PCI, int_ack=0, sync=0, int_pending=0. The first state after release is T1 → T2.
- int_pending:
  - Set when intr=1 at any clock edge.
  - Cleared on the edge that enters T1I.
  - "Pending" below means the registered flag OR intr on that same edge.
- Transitions, one per clk:
  - T1, T1I → T2.
  - T2 → T3 if ready=1, else → WAIT.
  - WAIT → T3 when ready=1, else stay in WAIT. There is no limit on the number of WAIT states.
  - T3:
    - If halt=1 and cyc_idx=0 → STOPPED. Halt wins over cyc_len and cyc_last.
    - Else if cyc_len=01 → end-of-cycle.
    - Else → T4.
  - T4 → end-of-cycle if cyc_len (as latched in T3) = 10, else → T5.
  - T5 → end-of-cycle.
  - STOPPED: stays in STOPPED until interrupt pending, then → T1I with cyc_idx=0 and cyc_type=PCI.
- End-of-cycle:
  - If cyc_last=1: cyc_idx←0, cyc_type←PCI; next state T1I if interrupt pending, else T1.
  - If cyc_last=0: cyc_idx←cyc_idx+1, cyc_type←next_type, next state T1. Interrupts are not taken mid-instruction.
  - If cyc_last=0 at cyc_idx=2: cyc_idx wraps to 0 and the cycle is treated as PCI (defensive behaviour; decode must never do this).
- cyc_len is latched in T3 into an internal 2-bit register. Changes to cyc_len after T3 are ignored.
- int_ack is set on entry to T1I and cleared at the next end-of-cycle or on reset.

## Timing
- All outputs are registered, with no combinational path from inputs to outputs.
- Minimum machine cycle is 3 clocks (T1,T2,T3) with ready=1; the maximum without waits is 5.
- Each WAIT adds exactly 1 clock. ready going high in WAIT gives T3 on the next edge.
- Interrupt latency from STOPPED: intr high at edge n gives state=T1I after edge n.
- Interrupt latency while running: T1I follows the end-of-cycle of the instruction's last cycle. An intr arriving on that same edge is taken.
- sync toggles every clk regardless of state, including in WAIT and STOPPED.

## Test plan
- Reset, then ready=1, cyc_len=01, cyc_last=1, no intr. Required: state sequence T1,T2,T3,T1,T2,T3…; cyc_idx stays 0; cyc_type stays PCI.
- 3-cycle instruction: cycle 0 with cyc_len=11, cyc_last=0, next_type=10; cycle 1 with cyc_len=10, cyc_last=0, next_type=11; cycle 2 with cyc_len=01, cyc_last=1. Required:
  - States: T1,T2,T3,T4,T5 / T1,T2,T3,T4 / T1,T2,T3 / T1.
  - cyc_idx: 0, 1, 2, then 0.
  - cyc_type: 00, 10, 11, then 00.
- ready=0 held for 3 clocks after T2. Required: exactly 3 WAIT states, then T3 on the edge after ready=1; cycle otherwise unchanged.
- halt=1 in T3 of cycle 0 → state STOPPED, held for 10 clocks. Then a 1-clock intr pulse. Required: T1I on the next edge, int_ack=1, cyc_type=PCI, then T2.
- intr pulsed during cycle 1 of a 2-cycle instruction. Required: no effect until the last cycle ends; then T1I, int_pending cleared, int_ack high through T3, and the following cycle starts in T1 with int_ack=0.
- rst_n pulled low asynchronously in WAIT with cyc_idx=1 and int_pending=1. Required: state=T1, cyc_idx=0, cyc_type=PCI, int_ack=0 immediately, with no clock needed. After release, T1 → T2, and no T1I occurs without a new intr.
